// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO: pointer Gray-code conversion and
// default geometry used by both the read and write controllers.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_WIDTH = 8;
    localparam int unsigned FIFO_ADDR_WIDTH = 6;

    // Mask keeping the low 'width' bits of a 32-bit pointer value.
    function automatic logic [31:0] width_mask(input int unsigned width);
        logic [31:0] m;
        if (width >= 32)
            m = '1;
        else
            m = (32'd1 << width) - 32'd1;
        return m;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin, input int unsigned width);
        logic [31:0] b;
        b = bin & width_mask(width);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int unsigned width);
        logic [31:0] g;
        logic [31:0] b;
        g = gray & width_mask(width);
        b = '0;
        for (int unsigned i = 0; i < width && i < 32; i++)
            b[i] = ^(g >> i);
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for multi-bit Gray pointers crossing clock domains.
module sync_2ff #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the asynchronous FIFO: read pointer, empty/occupancy
// from the synchronized write pointer, and a valid/ready output stage.
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk_rd,
    input  logic                  rst_rd,
    input  logic [ADDR_WIDTH:0]   wptr_gray,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   rd_count
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wq2_gray;
    logic [PW-1:0] wq2_bin;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_q;
    logic [PW-1:0] rgray_next;
    logic          valid_q;
    logic          empty_c;
    logic          issue;

    sync_2ff #(
        .WIDTH (PW)
    ) u_wptr_sync (
        .clk (clk_rd),
        .rst (rst_rd),
        .d   (wptr_gray),
        .q   (wq2_gray)
    );

    always_comb begin
        wq2_bin = PW'(gray2bin(32'(wq2_gray), PW));
        empty_c = (rbin == wq2_bin);
        // A word may leave memory only when the output slot is free or draining now.
        issue   = !empty_c && (!valid_q || dout_ready);
    end

    always_comb begin
        rbin_next  = rbin + {{(PW-1){1'b0}}, issue};
        rgray_next = PW'(bin2gray(32'(rbin_next), PW));
    end

    always_ff @(posedge clk_rd or posedge rst_rd) begin
        if (rst_rd) begin
            rbin    <= '0;
            rgray_q <= '0;
        end else begin
            rbin    <= rbin_next;
            rgray_q <= rgray_next;
        end
    end

    always_ff @(posedge clk_rd or posedge rst_rd) begin
        if (rst_rd)
            valid_q <= 1'b0;
        else if (issue)
            valid_q <= 1'b1;
        else if (dout_ready)
            valid_q <= 1'b0;
    end

    assign rptr_gray  = rgray_q;
    assign raddr      = rbin[ADDR_WIDTH-1:0];
    assign rd_en      = issue;
    assign empty      = empty_c;
    assign rd_count   = wq2_bin - rbin;
    assign dout       = mem_data;
    assign dout_valid = valid_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Randomized bench for fifo_read_ctrl against an integer-count reference model.
module tb_fifo_read_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk_rd = 1'b0;
    logic          rst_rd = 1'b1;
    logic [AW:0]   wptr_gray = '0;
    logic [AW:0]   rptr_gray;
    logic [AW-1:0] raddr;
    logic          rd_en;
    logic [DW-1:0] mem_data = '0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic          empty;
    logic [AW:0]   rd_count;

    fifo_read_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_rd     (clk_rd),
        .rst_rd     (rst_rd),
        .wptr_gray  (wptr_gray),
        .rptr_gray  (rptr_gray),
        .raddr      (raddr),
        .rd_en      (rd_en),
        .mem_data   (mem_data),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .empty      (empty),
        .rd_count   (rd_count)
    );

    always #5 clk_rd = ~clk_rd;

    // Dual-port memory read port with registered output.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk_rd)
        if (rd_en) mem_data <= mem[raddr];

    int dut_taken = 0;
    always @(posedge clk_rd)
        if (!rst_rd && dout_valid && dout_ready) dut_taken++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW:0] tb_gray(input int n);
        logic [AW:0] b;
        b = (AW+1)'(n % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    // Reference model: absolute word counts since reset.
    int          wcount;      // words written
    int          wp_d1, vis;  // write count one and two edges behind
    int          issued;      // words read from memory
    bit          presented;
    int          pres_idx;
    int          taken_base;
    logic [DW-1:0] wdata[$];
    logic [AW:0] prev_rg;

    task automatic model_reset();
        wcount = 0; wp_d1 = 0; vis = 0; issued = 0;
        presented = 0; pres_idx = 0; prev_rg = '0;
        wdata.delete();
        wptr_gray = '0;
        taken_base = dut_taken;
    endtask

    // mode: 0 random data, 1 sequential data, 2 fixed value
    task automatic step(input bit rdy, input int nw, input int mode, input logic [DW-1:0] val);
        bit can;
        logic [DW-1:0] d;
        @(negedge clk_rd);
        check("dout_valid", dout_valid, presented);
        if (presented) check("dout", dout, wdata[pres_idx]);
        check("rptr_gray", rptr_gray, tb_gray(issued));
        check("rptr_gray_onebit", ($countones(rptr_gray ^ prev_rg) <= 1), 1);
        prev_rg = rptr_gray;

        dout_ready = rdy;
        for (int k = 0; k < nw; k++) begin
            if (wcount - issued < DEPTH) begin
                d = (mode == 0) ? DW'($urandom) : (mode == 1) ? DW'(wcount) : val;
                wdata.push_back(d);
                mem[wcount % DEPTH] = d;
                wcount++;
            end
        end
        wptr_gray = tb_gray(wcount);
        #1;
        can = (vis > issued) && (!presented || rdy);
        check("empty", empty, (vis == issued));
        check("rd_count", rd_count, vis - issued);
        check("rd_en", rd_en, can);
        check("raddr", raddr, issued % DEPTH);

        if (can) begin
            presented = 1; pres_idx = issued; issued++;
        end else if (rdy) begin
            presented = 0;
        end
        vis   = wp_d1;
        wp_d1 = wcount;
    endtask

    task automatic mid_reset();
        @(negedge clk_rd);
        #2 rst_rd = 1'b1;
        #1;
        check("rst_dout_valid", dout_valid, 0);
        check("rst_rptr_gray", rptr_gray, 0);
        check("rst_empty", empty, 1);
        check("rst_rd_count", rd_count, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_raddr", raddr, 0);
        model_reset();
        @(negedge clk_rd);
        rst_rd = 1'b0;
    endtask

    int target;

    initial begin
        model_reset();
        #1;
        check("init_empty", empty, 1);
        check("init_dout_valid", dout_valid, 0);
        @(negedge clk_rd);
        @(negedge clk_rd);
        rst_rd = 1'b0;

        // Single word
        step(1, 1, 2, 8'hA5);
        for (int i = 0; i < 6; i++) step(1, 0, 0, '0);

        // Backpressure: four words, consumer stalled, then released
        step(0, 4, 0, '0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, '0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, '0);

        // Reset while a word is presented
        step(0, 2, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, '0);
        mid_reset();

        // Full occupancy in one jump, then drain through the address wrap
        step(0, 64, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0);
        for (int i = 0; i < 72; i++) step(1, 0, 0, '0);

        // 256 sequential words streamed through both pointer wraps
        target = wcount + 256;
        for (int i = 0; i < 300; i++) step(1, (wcount < target) ? 1 : 0, 1, '0);

        // Last word consumed on the same edge a new write arrives
        step(0, 1, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, '0);
        step(1, 1, 0, '0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, '0);

        // Random traffic
        for (int i = 0; i < 1500; i++)
            step(($urandom % 4) != 0, int'($urandom % 3), 0, '0);
        for (int i = 0; i < 100; i++) step(1, 0, 0, '0);

        check("words_delivered", dut_taken - taken_base, wcount);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
